// File: rtl/uart_pkg.sv
// Shared UART TX definitions: frame FSM state encoding and parity-type constants.
// Parity type is 2 bits: 00 none, x1 odd, 10 even.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Odd parity is selected by bit 0 alone, whatever bit 1 holds.
  function automatic logic par_is_odd(input logic [1:0] parity_type);
    return parity_type[0];
  endfunction

endpackage

// File: rtl/parity.sv
// Combinational parity generator for a 7- or 8-bit character; zero latency, no handshake.
// Drives 0 when parity is disabled.
module parity
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  output logic       parity_bit
);

  logic ones_odd;

  always_comb begin
    ones_odd = (^data[6:0]) ^ (data_length & data[7]);
    if (par_is_odd(parity_type)) begin
      parity_bit = ~ones_odd;
    end else if (parity_type == PAR_EVEN) begin
      parity_bit = ones_odd;
    end else begin
      parity_bit = 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX framer: tx goes low on the edge after accept, each bit lasts CLKS_PER_BIT clocks; tx_ready only in IDLE.
// UART_TX_BREAK_EN: send_break holds the idle line low and blocks accepts; otherwise send_break is ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       send_break,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              len_q, len_d;
  logic [1:0]        ptype_q, ptype_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic       par_bit;
  logic       brk;
  logic       accept;
  logic       bit_end;
  logic [2:0] last_bit;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  logic unused_send_break;
  assign unused_send_break = send_break;
  assign brk = 1'b0;
`endif

  parity u_parity (
    .data        (data_q),
    .data_length (len_q),
    .parity_type (ptype_q),
    .parity_bit  (par_bit)
  );

  assign tx_ready = (state_q == IDLE) && !brk;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (baud_q == BAUD_LAST);
  assign last_bit = len_q ? 3'd7 : 3'd6;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    len_d   = len_q;
    ptype_d = ptype_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = 3'd0;
          data_d  = tx_data;
          len_d   = data_length;
          ptype_d = parity_type;
          stop2_d = stop_bits;
          shift_d = {tx_data[7] & data_length, tx_data[6:0]};
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == last_bit) begin
            bit_d   = 3'd0;
            state_d = (ptype_q == PAR_NONE) ? STOP : PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // bit_q doubles as the stop-bit index in this state.
          if (stop2_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            bit_d   = 3'd0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase

    // Line level is derived from the next state so tx lands on the same edge as the transition.
    case (state_d)
      IDLE:    tx_d = ~brk;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      len_q   <= 1'b0;
      ptype_q <= PAR_NONE;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ptype_q <= ptype_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLKS_PER_BIT=4: table of frames plus back-to-back, reset and break sequences.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       data_length = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       send_break = 1'b0;
  logic       tx;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  logic exp_idle_tx = 1'b1;

  uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .data_length (data_length),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .send_break  (send_break),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // bits[i] is the i-th serial bit on the line, start bit first.
  typedef struct {
    logic [7:0]  data;
    logic        len;
    logic [1:0]  ptype;
    logic        stop2;
    logic [11:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after the accepting posedge; checks every clock of the frame and the done cycle.
  task automatic check_frame(input vec_t v, input int id, input bit drop);
    for (int k = 0; k < v.nbits * CPB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk($sformatf("busy f%0d", id), tx_busy, 1);
        chk($sformatf("ready_low f%0d", id), tx_ready, 0);
        if (drop) begin
          tx_valid    = 1'b0;
          tx_data     = ~v.data;
          data_length = ~v.len;
          parity_type = ~v.ptype;
          stop_bits   = ~v.stop2;
        end
      end
      chk($sformatf("tx f%0d k%0d", id, k), tx, v.bits[k / CPB]);
    end
    @(negedge clk);
    exp_done++;
    chk($sformatf("done f%0d", id), tx_done, 1);
    chk($sformatf("ready_end f%0d", id), tx_ready, exp_idle_tx);
    chk($sformatf("busy_end f%0d", id), tx_busy, 0);
    chk($sformatf("tx_end f%0d", id), tx, exp_idle_tx);
  endtask

  task automatic drive(input vec_t v);
    tx_data     = v.data;
    data_length = v.len;
    parity_type = v.ptype;
    stop_bits   = v.stop2;
    tx_valid    = 1'b1;
  endtask

  task automatic send(input vec_t v, input int id);
    @(negedge clk);
    chk($sformatf("ready_start f%0d", id), tx_ready, 1);
    drive(v);
    @(posedge clk);
    check_frame(v, id, 1'b1);
  endtask

  initial begin
    // 8N1 0x55
    vecs[0] = '{data: 8'h55, len: 1'b1, ptype: 2'b00, stop2: 1'b0, bits: 12'h2AA, nbits: 10};
    // 7E1 0xC1: bit 7 must be ignored, sends 0x41
    vecs[1] = '{data: 8'hC1, len: 1'b0, ptype: 2'b10, stop2: 1'b0, bits: 12'h282, nbits: 10};
    // 8O2 0x41
    vecs[2] = '{data: 8'h41, len: 1'b1, ptype: 2'b01, stop2: 1'b1, bits: 12'hE82, nbits: 12};
    // 8E1 0xA5
    vecs[3] = '{data: 8'hA5, len: 1'b1, ptype: 2'b10, stop2: 1'b0, bits: 12'h54A, nbits: 11};
    // 7O2 0x3C with odd encoded as 2'b11
    vecs[4] = '{data: 8'h3C, len: 1'b0, ptype: 2'b11, stop2: 1'b1, bits: 12'h778, nbits: 11};
    // 7N1 0xFF
    vecs[5] = '{data: 8'hFF, len: 1'b0, ptype: 2'b00, stop2: 1'b0, bits: 12'h1FE, nbits: 9};

    #2 rst_n = 1'b0;
    #1;
    chk("rst tx", tx, 1);
    chk("rst ready", tx_ready, 1);
    chk("rst busy", tx_busy, 0);
    chk("rst done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no valid: line stays high, no done.
    repeat (10) @(negedge clk);
    chk("idle tx", tx, 1);
    chk("idle done_cnt", done_cnt, exp_done);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i], i);
    end
    @(negedge clk);
    chk("table done_cnt", done_cnt, exp_done);

    // Back-to-back with tx_valid held: second start bit right after the done cycle.
    @(negedge clk);
    drive(vecs[3]);
    @(posedge clk);
    check_frame(vecs[3], 10, 1'b0);
    drive(vecs[4]);
    @(posedge clk);
    check_frame(vecs[4], 11, 1'b1);
    @(negedge clk);
    chk("b2b done_cnt", done_cnt, exp_done);

    // Reset at clock 17 of a frame.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid = 1'b0;
    end
    chk("pre_rst tx", tx, vecs[0].bits[17 / CPB]);
    rst_n = 1'b0;
    #1;
    chk("midrst tx", tx, 1);
    chk("midrst busy", tx_busy, 0);
    chk("midrst ready", tx_ready, 1);
    chk("midrst done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("postrst tx", tx, 1);
    chk("postrst done_cnt", done_cnt, exp_done);
    send(vecs[2], 20);
    @(negedge clk);
    chk("postrst frame done_cnt", done_cnt, exp_done);

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    send_break = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    chk("brk tx", tx, 0);
    chk("brk ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    chk("brk busy", tx_busy, 0);
    chk("brk tx hold", tx, 0);
    tx_valid   = 1'b0;
    send_break = 1'b0;
    @(negedge clk);
    chk("brk release tx", tx, 1);
    chk("brk release ready", tx_ready, 1);

    // Break raised mid-frame: frame completes, then line drops.
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    #1;
    send_break  = 1'b1;
    exp_idle_tx = 1'b0;
    check_frame(vecs[1], 30, 1'b1);
    send_break  = 1'b0;
    exp_idle_tx = 1'b1;
    @(negedge clk);
    chk("brk2 release tx", tx, 1);
    chk("brk2 done_cnt", done_cnt, exp_done);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
